// File: rtl/pico_io_pkg.sv
// Shared port map and scheduler state encoding for the
// pico sample scheduler slice.
package pico_io_pkg;

    localparam logic [7:0] PORT_FIFO   = 8'h00;
    localparam logic [7:0] PORT_STATUS = 8'h01;

    localparam int WR_LED_BIT     = 7;
    localparam int WR_LEDADDR_BIT = 6;
    localparam int WR_OVF_CLR_BIT = 5;
    localparam int WR_EOS_BIT     = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PENDING,
        ST_SERVICE
    } sched_state_t;

endpackage

// File: rtl/pico_sample_sched_fifo.sv
// Sample FIFO: power-of-two ring buffer with simultaneous
// push/pop, count, full/empty flags and a drop indication.
module sample_fifo
    import pico_io_pkg::*;
#(
    parameter  int DEPTH  = 8,
    parameter  int DATA_W = 8,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] head,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty,
    output logic              drop
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A pop frees a slot in the same cycle, so a full FIFO still
    // accepts a push when it is also being popped.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    assign head = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/pico_sample_sched.sv
// Audio sample scheduler: queues samples and interrupts a small
// processor, which drains them through its I/O port space.
module pico_sample_sched
    import pico_io_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [7:0]        port_id,
    input  logic              read_strobe,
    input  logic              write_strobe,
    input  logic [7:0]        out_port,
    output logic [7:0]        in_port,
    output logic              interrupt,
    input  logic              interrupt_ack,
    output logic [7:0]        led,
    output logic [7:0]        ledaddr,
    output logic              overflow
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0] head;
    logic [CW-1:0]     count;
    logic [4:0]        count5;
    logic              full;
    logic              empty;
    logic              drop;
    logic              pop_req;
    logic              wr_led;
    logic              wr_ledaddr;
    logic              wr_ovf_clr;
    logic              eos;
    sched_state_t      state_q;
    sched_state_t      state_d;

    assign pop_req    = read_strobe && (port_id == PORT_FIFO);
    assign wr_led     = write_strobe && port_id[WR_LED_BIT];
    assign wr_ledaddr = write_strobe && port_id[WR_LEDADDR_BIT];
    assign wr_ovf_clr = write_strobe && port_id[WR_OVF_CLR_BIT];
    assign eos        = write_strobe && port_id[WR_EOS_BIT];
    assign count5     = 5'(count);

    sample_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (sample_valid),
        .pop   (pop_req),
        .wdata (sample_data),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty),
        .drop  (drop)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            in_port <= '0;
        end else begin
            case (port_id)
                PORT_FIFO:   in_port <= 8'(head);
                PORT_STATUS: in_port <= {overflow, 2'b00, count5};
                default:     in_port <= '0;
            endcase
        end
    end

    // A drop in the same cycle as a clear must leave the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            led      <= '0;
            ledaddr  <= '0;
        end else begin
            if (drop)            overflow <= 1'b1;
            else if (wr_ovf_clr) overflow <= 1'b0;
            if (wr_led)          led      <= out_port;
            if (wr_ledaddr)      ledaddr  <= out_port;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (!empty)        state_d = ST_PENDING;
            ST_PENDING: if (interrupt_ack) state_d = ST_SERVICE;
            ST_SERVICE: if (eos)           state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            interrupt <= 1'b0;
        end else begin
            state_q   <= state_d;
            interrupt <= (state_d == ST_PENDING);
        end
    end

    logic unused_full;
    assign unused_full = full;

endmodule

// File: tb/tb_pico_sample_sched.sv
// Directed bench for pico_sample_sched: vector table plus
// hand-written sequences for fill, overflow, EOS and reset.
module tb_pico_sample_sched;

    logic       clk;
    logic       reset;
    logic       sample_valid;
    logic [7:0] sample_data;
    logic [7:0] port_id;
    logic       read_strobe;
    logic       write_strobe;
    logic [7:0] out_port;
    logic [7:0] in_port;
    logic       interrupt;
    logic       interrupt_ack;
    logic [7:0] led;
    logic [7:0] ledaddr;
    logic       overflow;

    int checks;
    int failures;

    pico_sample_sched #(
        .FIFO_DEPTH (8),
        .DATA_W     (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_valid  (sample_valid),
        .sample_data   (sample_data),
        .port_id       (port_id),
        .read_strobe   (read_strobe),
        .write_strobe  (write_strobe),
        .out_port      (out_port),
        .in_port       (in_port),
        .interrupt     (interrupt),
        .interrupt_ack (interrupt_ack),
        .led           (led),
        .ledaddr       (ledaddr),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sv;
        logic [7:0] sd;
        logic [7:0] pid;
        logic       rs;
        logic       ws;
        logic [7:0] op;
        logic       ack;
        logic [7:0] e_in;
        logic       e_int;
        logic [7:0] e_led;
        logic [7:0] e_la;
        logic       e_ovf;
    } vec_t;

    vec_t vt[13];

    function automatic vec_t mk(
        input logic sv, input logic [7:0] sd, input logic [7:0] pid,
        input logic rs, input logic ws, input logic [7:0] op,
        input logic ack, input logic [7:0] e_in, input logic e_int,
        input logic [7:0] e_led, input logic [7:0] e_la,
        input logic e_ovf);
        vec_t v;
        v.sv = sv; v.sd = sd; v.pid = pid; v.rs = rs; v.ws = ws;
        v.op = op; v.ack = ack; v.e_in = e_in; v.e_int = e_int;
        v.e_led = e_led; v.e_la = e_la; v.e_ovf = e_ovf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic drv(input logic sv, input logic [7:0] sd,
                       input logic [7:0] pid, input logic rs,
                       input logic ws, input logic [7:0] op,
                       input logic ack);
        sample_valid  = sv;
        sample_data   = sd;
        port_id       = pid;
        read_strobe   = rs;
        write_strobe  = ws;
        out_port      = op;
        interrupt_ack = ack;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        drv(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        drv(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

        // sv sd pid rs ws op ack | in int led la ovf
        vt[0]  = mk(1, 8'hA5, 8'h01, 0, 0, 8'h00, 0,
                    8'h00, 0, 8'h00, 8'h00, 0);
        vt[1]  = mk(0, 8'h00, 8'h01, 0, 0, 8'h00, 0,
                    8'h01, 1, 8'h00, 8'h00, 0);
        vt[2]  = mk(0, 8'h00, 8'h01, 0, 0, 8'h00, 1,
                    8'h01, 0, 8'h00, 8'h00, 0);
        vt[3]  = mk(0, 8'h00, 8'h00, 1, 0, 8'h00, 0,
                    8'hA5, 0, 8'h00, 8'h00, 0);
        vt[4]  = mk(0, 8'h00, 8'h01, 0, 0, 8'h00, 0,
                    8'h00, 0, 8'h00, 8'h00, 0);
        vt[5]  = mk(0, 8'h00, 8'h10, 0, 1, 8'h00, 0,
                    8'h00, 0, 8'h00, 8'h00, 0);
        vt[6]  = mk(0, 8'h00, 8'h80, 0, 1, 8'h3C, 0,
                    8'h00, 0, 8'h3C, 8'h00, 0);
        vt[7]  = mk(0, 8'h00, 8'h40, 0, 1, 8'hC3, 0,
                    8'h00, 0, 8'h3C, 8'hC3, 0);
        vt[8]  = mk(0, 8'h00, 8'hC0, 0, 1, 8'h5A, 0,
                    8'h00, 0, 8'h5A, 8'h5A, 0);
        vt[9]  = mk(0, 8'h00, 8'h01, 0, 0, 8'h00, 1,
                    8'h00, 0, 8'h5A, 8'h5A, 0);
        vt[10] = mk(0, 8'h00, 8'h00, 1, 0, 8'h00, 0,
                    8'h00, 0, 8'h5A, 8'h5A, 0);
        vt[11] = mk(0, 8'h00, 8'h01, 0, 0, 8'h00, 0,
                    8'h00, 0, 8'h5A, 8'h5A, 0);
        vt[12] = mk(0, 8'h00, 8'h80, 0, 0, 8'hFF, 0,
                    8'h00, 0, 8'h5A, 8'h5A, 0);

        tick();
        chk("rst.in_port", in_port, 8'h00);
        chk("rst.interrupt", {7'd0, interrupt}, 8'h00);
        chk("rst.led", led, 8'h00);
        chk("rst.ledaddr", ledaddr, 8'h00);
        chk("rst.overflow", {7'd0, overflow}, 8'h00);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drv(vt[i].sv, vt[i].sd, vt[i].pid, vt[i].rs,
                vt[i].ws, vt[i].op, vt[i].ack);
            tick();
            chk($sformatf("vec%0d.in_port", i), in_port, vt[i].e_in);
            chk($sformatf("vec%0d.interrupt", i),
                {7'd0, interrupt}, {7'd0, vt[i].e_int});
            chk($sformatf("vec%0d.led", i), led, vt[i].e_led);
            chk($sformatf("vec%0d.ledaddr", i), ledaddr, vt[i].e_la);
            chk($sformatf("vec%0d.overflow", i),
                {7'd0, overflow}, {7'd0, vt[i].e_ovf});
        end

        // Fill past capacity, then clear the sticky flag
        do_reset();
        for (int k = 0; k < 9; k++) begin
            drv(1'b1, 8'(8'h10 + k), 8'h01, 1'b0, 1'b0, 8'h00, 1'b0);
            tick();
        end
        drv(1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        chk("fill.status", in_port, 8'h88);
        chk("fill.overflow", {7'd0, overflow}, 8'h01);
        drv(1'b0, 8'h00, 8'h20, 1'b0, 1'b1, 8'h00, 1'b0);
        tick();
        chk("clr.overflow", {7'd0, overflow}, 8'h00);
        drv(1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        chk("clr.status", in_port, 8'h08);

        // Full FIFO: push and pop together
        drv(1'b1, 8'h99, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        chk("pp.popped", in_port, 8'h10);
        chk("pp.overflow", {7'd0, overflow}, 8'h00);
        drv(1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        chk("pp.status", in_port, 8'h08);

        // Drop coinciding with a clear keeps the flag set
        drv(1'b1, 8'h77, 8'h20, 1'b0, 1'b1, 8'h00, 1'b0);
        tick();
        chk("setclr.overflow", {7'd0, overflow}, 8'h01);
        drv(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        chk("setclr.popped", in_port, 8'h11);
        drv(1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        chk("setclr.status", in_port, 8'h87);

        // EOS with samples still queued re-raises the interrupt
        do_reset();
        drv(1'b1, 8'h01, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        drv(1'b1, 8'h02, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        chk("eos.int_pending", {7'd0, interrupt}, 8'h01);
        drv(1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        chk("eos.int_ack", {7'd0, interrupt}, 8'h00);
        drv(1'b0, 8'h00, 8'h10, 1'b0, 1'b1, 8'h00, 1'b0);
        tick();
        chk("eos.int_idle", {7'd0, interrupt}, 8'h00);
        drv(1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        chk("eos.int_again", {7'd0, interrupt}, 8'h01);
        chk("eos.status", in_port, 8'h02);

        // Reset while in service with three samples queued
        do_reset();
        drv(1'b0, 8'h00, 8'hC0, 1'b0, 1'b1, 8'hAA, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drv(1'b1, 8'(8'h31 + k), 8'h01, 1'b0, 1'b0, 8'h00, 1'b0);
            tick();
        end
        drv(1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        drv(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        chk("svc.head", in_port, 8'h31);
        chk("svc.led", led, 8'hAA);
        reset = 1'b1;
        drv(1'b1, 8'h55, 8'hF0, 1'b1, 1'b1, 8'hFF, 1'b1);
        tick();
        reset = 1'b0;
        chk("rst2.in_port", in_port, 8'h00);
        chk("rst2.led", led, 8'h00);
        chk("rst2.ledaddr", ledaddr, 8'h00);
        chk("rst2.overflow", {7'd0, overflow}, 8'h00);
        chk("rst2.interrupt", {7'd0, interrupt}, 8'h00);
        for (int k = 0; k < 4; k++) begin
            drv(1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
            tick();
            chk($sformatf("post%0d.status", k), in_port, 8'h00);
            chk($sformatf("post%0d.interrupt", k),
                {7'd0, interrupt}, 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pico_sample_sched.md
PICO_SAMPLE_SCHED -- requirements
Module: pico_sample_sched

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, sample FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter DATA_W, default 8, sample width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port sample_valid  input  1  one-cycle strobe; sample_data is valid this cycle.
REQ-006 SHALL have port sample_data  input  DATA_W  audio sample to enqueue.
REQ-007 SHALL have port port_id  input  8  processor port address.
REQ-008 SHALL have port read_strobe  input  1  processor read qualifier.
REQ-009 SHALL have port write_strobe  input  1  processor write qualifier.
REQ-010 SHALL have port out_port  input  8  processor write data.
REQ-011 SHALL have port in_port  output  8  registered processor read data.
REQ-012 SHALL have port interrupt  output  1  registered interrupt request to the processor.
REQ-013 SHALL have port interrupt_ack  input  1  processor interrupt acknowledge, synchronous.
REQ-014 SHALL have port led  output  8  LED register.
REQ-015 SHALL have port ledaddr  output  8  LED address register.
REQ-016 SHALL have port overflow  output  1  sticky sample-drop flag.

Function
REQ-017 SHALL enqueue sample_data on a clk edge where sample_valid=1 and the FIFO is not full.
REQ-018 SHALL drop the sample and set overflow when sample_valid=1, the FIFO is full and no pop occurs in the same cycle.
REQ-019 SHALL perform push and pop in the same cycle when full (count unchanged, no overflow) or when empty (push only; pop returns 0).
REQ-020 SHALL pop the FIFO head on read_strobe=1 with port_id=8'h00; in_port=popped value on the next edge; pop when empty returns 8'h00 and leaves the FIFO unchanged.
REQ-021 SHALL register in_port every cycle from port_id: 8'h00 -> FIFO head, 8'h01 -> {overflow, 2'b0, count[4:0]}, any other -> 8'h00.
REQ-022 SHALL decode writes one-hot on write_strobe: port_id[7] -> led<=out_port; port_id[6] -> ledaddr<=out_port; port_id[5] -> clear overflow; port_id[4] -> end-of-service (EOS); multiple bits set act on all.
REQ-023 SHALL let a set of overflow in the same cycle as a clear win (overflow stays 1).
REQ-024 SHALL implement states IDLE, PENDING, SERVICE; interrupt=1 iff state=PENDING (registered).
REQ-025 SHALL transition IDLE->PENDING on an edge where count!=0, so interrupt rises 2 edges after the sample_valid edge into an empty FIFO.
REQ-026 SHALL transition PENDING->SERVICE on interrupt_ack=1; interrupt falls on that edge.
REQ-027 SHALL transition SERVICE->IDLE on EOS; it SHALL re-enter PENDING on the following edge if count!=0.
REQ-028 SHALL ignore interrupt_ack outside PENDING and EOS outside SERVICE.
REQ-029 SHALL keep pointers modulo FIFO_DEPTH, with count 0..FIFO_DEPTH and full when count=FIFO_DEPTH.

Reset
REQ-030 SHALL, on reset, clear state to IDLE, pointers/count to 0, and in_port, led, ledaddr, overflow and interrupt to 0 on the same edge.
REQ-031 SHALL discard FIFO contents on reset mid-service and ignore all inputs in the reset cycle.

Structure
REQ-032 SHALL place port addresses (8'h00, 8'h01, write bits 7/6/5/4) and the state enum in shared package pico_io_pkg.
REQ-033 SHALL instantiate one sub-module, sample_fifo (push/pop/count/full/empty), inside pico_sample_sched.

Verification
REQ-034 SHALL test: one sample 8'hA5 into empty FIFO -> interrupt=1 two edges later; ack -> interrupt=0; read port 00 -> in_port=8'hA5; EOS -> IDLE.
REQ-035 SHALL test: 9 samples at FIFO_DEPTH=8 without reads -> count=8, overflow=1, status read=8'h88; write port 8'h20 -> overflow=0.
REQ-036 SHALL test: FIFO full plus push and pop in the same cycle -> count stays 8, overflow stays 0, popped value is the oldest sample.
REQ-037 SHALL test: pop on empty -> in_port=8'h00, count=0; ack while IDLE -> no state change.
REQ-038 SHALL test: EOS with 2 samples queued -> IDLE then PENDING next edge, interrupt=1.
REQ-039 SHALL test: reset asserted in SERVICE with 3 queued samples -> all outputs 0, count=0, interrupt stays 0 afterward.
